// File: rtl/fp_class_encode.sv
// Floating-point class encoder: packs {class, sign, exponent, mantissa} into IEEE-style fields.
// One registered output stage plus a skid entry keeps in_ready registered and throughput at 1/cycle.
module fp_class_encode #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [SIGN_W-1:0] in_sign,
  input  logic [EXPO_W-1:0] in_expo,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIGN_W-1:0] out_sign,
  output logic [EXPO_W-1:0] out_expo,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_err,
  output logic [15:0]       special_cnt
);

  localparam logic [2:0] CLS_NORMAL = 3'd0;
  localparam logic [2:0] CLS_ZERO   = 3'd1;
  localparam logic [2:0] CLS_INF    = 3'd2;
  localparam logic [2:0] CLS_QNAN   = 3'd3;
  localparam logic [2:0] CLS_SNAN   = 3'd4;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t r_state, w_nstate;

  logic              w_acc, w_deq;
  logic              w_ld_out_in, w_ld_out_skid, w_ld_skid;

  logic [SIGN_W-1:0] w_sign;
  logic [EXPO_W-1:0] w_expo;
  logic [MANT_W-1:0] w_mant;
  logic              w_err, w_spec;

  logic              r_in_ready, r_out_valid;
  logic [SIGN_W-1:0] r_out_sign, r_skid_sign;
  logic [EXPO_W-1:0] r_out_expo, r_skid_expo;
  logic [MANT_W-1:0] r_out_mant, r_skid_mant;
  logic              r_out_err, r_skid_err;
  logic              r_out_spec, r_skid_spec;
  logic [15:0]       r_cnt;

  // Combinational field encoding of the incoming request.
  always_comb begin
    w_sign = in_sign;
    w_expo = '0;
    w_mant = '0;
    w_err  = 1'b0;
    w_spec = 1'b1;
    case (in_class)
      CLS_NORMAL: begin
        w_spec = 1'b0;
        if (in_expo == '1) begin
          w_expo = {{(EXPO_W-1){1'b1}}, 1'b0};
          w_mant = '1;
          w_err  = 1'b1;
        end else begin
          w_expo = in_expo;
          w_mant = in_mant;
        end
      end
      CLS_ZERO: ;
      CLS_INF: w_expo = '1;
      CLS_QNAN: begin
        w_expo = '1;
        w_mant = {1'b1, in_mant[MANT_W-2:0]};
      end
      CLS_SNAN: begin
        w_expo = '1;
        w_mant = {1'b0, in_mant[MANT_W-2:0]};
        // A zero payload would read back as infinity, so force it non-zero.
        if (in_mant[MANT_W-2:0] == '0) w_mant[0] = 1'b1;
      end
      default: begin
        w_expo = '1;
        w_mant = {1'b1, {(MANT_W-1){1'b0}}};
        w_err  = 1'b1;
      end
    endcase
  end

  assign w_acc = in_valid && r_in_ready;
  assign w_deq = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate      = r_state;
    w_ld_out_in   = 1'b0;
    w_ld_out_skid = 1'b0;
    w_ld_skid     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_nstate    = S_ONE;
          w_ld_out_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_acc && w_deq) begin
          w_ld_out_in = 1'b1;
        end else if (w_acc) begin
          w_nstate  = S_TWO;
          w_ld_skid = 1'b1;
        end else if (w_deq) begin
          w_nstate = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_deq) begin
          w_nstate      = S_ONE;
          w_ld_out_skid = 1'b1;
        end
      end
      default: w_nstate = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sign  <= '0;
      r_out_expo  <= '0;
      r_out_mant  <= '0;
      r_out_err   <= 1'b0;
      r_out_spec  <= 1'b0;
      r_skid_sign <= '0;
      r_skid_expo <= '0;
      r_skid_mant <= '0;
      r_skid_err  <= 1'b0;
      r_skid_spec <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_in_ready  <= (w_nstate != S_TWO);
      r_out_valid <= (w_nstate != S_EMPTY);
      if (w_ld_out_in) begin
        r_out_sign <= w_sign;
        r_out_expo <= w_expo;
        r_out_mant <= w_mant;
        r_out_err  <= w_err;
        r_out_spec <= w_spec;
      end else if (w_ld_out_skid) begin
        r_out_sign <= r_skid_sign;
        r_out_expo <= r_skid_expo;
        r_out_mant <= r_skid_mant;
        r_out_err  <= r_skid_err;
        r_out_spec <= r_skid_spec;
      end
      if (w_ld_skid) begin
        r_skid_sign <= w_sign;
        r_skid_expo <= w_expo;
        r_skid_mant <= w_mant;
        r_skid_err  <= w_err;
        r_skid_spec <= w_spec;
      end
      if (w_deq && r_out_spec && (r_cnt != '1)) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_sign    = r_out_sign;
  assign out_expo    = r_out_expo;
  assign out_mant    = r_out_mant;
  assign out_err     = r_out_err;
  assign special_cnt = r_cnt;

endmodule
